// File: rtl/jesd204b_rx_link_ctrl.sv
// jesd204b_rx_link_ctrl: subclass-1 JESD204B receive link sequencer (SYSREF, CGS, ILAS, DATA)
module jesd204b_rx_link_ctrl #(
    parameter int unsigned LANES        = 1,
    parameter int unsigned CGS_K_CNT    = 4,
    parameter int unsigned ILAS_MF      = 4,
    parameter int unsigned ILAS_TIMEOUT = 4,
    parameter int unsigned RBD          = 0,
    parameter int unsigned ERR_THRESH   = 4
) (
    input  logic             dclk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_sysref_done,
    input  logic             i_lmfc,
    input  logic [LANES-1:0] i_lane_k28_5,
    input  logic [LANES-1:0] i_lane_ila_start,
    input  logic [LANES-1:0] i_lane_err,
    output logic             o_sync_n,
    output logic             o_release,
    output logic             o_link_up,
    output logic [2:0]       o_state,
    output logic [7:0]       o_resync_cnt
);
    localparam int unsigned KW = $clog2(CGS_K_CNT + 1);
    localparam int unsigned TW = $clog2(ILAS_TIMEOUT + 1);
    localparam int unsigned MW = $clog2(ILAS_MF + 1);
    localparam logic [KW-1:0] K_MAX  = KW'(CGS_K_CNT);
    localparam logic [TW-1:0] TO_MAX = TW'(ILAS_TIMEOUT);
    localparam logic [MW-1:0] MF_MAX = MW'(ILAS_MF);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_SYSREF = 3'd1,
        CGS         = 3'd2,
        WAIT_ILAS   = 3'd3,
        ILAS        = 3'd4,
        DATA        = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             lmfc_q;
    logic [KW-1:0]    k_cnt_q [LANES];
    logic [KW-1:0]    k_cnt_d [LANES];
    logic             cgs_ok_q, cgs_ok_d;
    logic [LANES-1:0] ila_seen_q, ila_seen_d;
    logic [TW-1:0]    to_q, to_d;
    logic [MW-1:0]    mf_q, mf_d;
    logic [7:0]       rbd_q, rbd_d;
    logic [7:0]       err_q, err_d;
    logic [7:0]       resync_q, resync_d;
    logic             sync_n_q, sync_n_d;
    logic             release_q, release_d;
    logic             link_up_q, link_up_d;
    logic             lmfc_edge;
    logic             all_k;
    logic             resync;
    logic [8:0]       err_sum;
    logic [8:0]       err_acc;

    assign lmfc_edge    = i_lmfc & ~lmfc_q;
    assign o_state      = state_q;
    assign o_sync_n     = sync_n_q;
    assign o_release    = release_q;
    assign o_link_up    = link_up_q;
    assign o_resync_cnt = resync_q;

    // Next-state and bookkeeping; per-state counters default to zero so leaving a state clears them
    always_comb begin
        state_d    = state_q;
        cgs_ok_d   = 1'b0;
        ila_seen_d = '0;
        to_d       = '0;
        mf_d       = '0;
        rbd_d      = '0;
        err_d      = '0;
        err_acc    = '0;
        all_k      = 1'b1;
        resync     = 1'b0;
        err_sum    = '0;
        for (int i = 0; i < LANES; i++) begin
            k_cnt_d[i] = '0;
            err_sum    = err_sum + 9'(i_lane_err[i]);
        end
        case (state_q)
            IDLE: state_d = WAIT_SYSREF;
            WAIT_SYSREF: if (i_sysref_done) state_d = CGS;
            CGS: begin
                for (int i = 0; i < LANES; i++) begin
                    k_cnt_d[i] = (i_lane_k28_5[i] && !i_lane_err[i]) ?
                                 ((k_cnt_q[i] == K_MAX) ? K_MAX : k_cnt_q[i] + 1'b1) : '0;
                    all_k = all_k & (k_cnt_d[i] == K_MAX);
                end
                cgs_ok_d = cgs_ok_q | all_k;
                if (cgs_ok_d && lmfc_edge) state_d = WAIT_ILAS;
            end
            WAIT_ILAS: begin
                ila_seen_d = ila_seen_q | i_lane_ila_start;
                to_d       = to_q + TW'(lmfc_edge);
                if (&ila_seen_d) state_d = ILAS;
                else if (to_d == TO_MAX) resync = 1'b1;
            end
            ILAS: begin
                if (rbd_q != 8'd0) begin
                    if (rbd_q == 8'd1) state_d = DATA;
                    else rbd_d = rbd_q - 8'd1;
                end else begin
                    mf_d = mf_q + MW'(lmfc_edge);
                    if (mf_d == MF_MAX) begin
                        if (RBD == 0) state_d = DATA;
                        else rbd_d = 8'(RBD);
                    end
                end
            end
            DATA: begin
                err_acc = (lmfc_edge ? 9'd0 : {1'b0, err_q}) + err_sum;
                err_d   = err_acc[8] ? 8'hff : err_acc[7:0];
                if (err_acc >= 9'(ERR_THRESH)) resync = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (resync) state_d = CGS;
        resync_d = (resync && resync_q != 8'hff) ? resync_q + 8'd1 : resync_q;
        if (!i_enable) begin
            state_d  = IDLE;
            resync_d = resync_q;
        end
        sync_n_d  = state_d != CGS;
        release_d = state_d == DATA;
        link_up_d = state_d == DATA;
    end

    // State, counters and registered outputs
    always_ff @(posedge dclk) begin
        if (rst) begin
            state_q    <= IDLE;
            lmfc_q     <= 1'b0;
            k_cnt_q    <= '{default: '0};
            cgs_ok_q   <= 1'b0;
            ila_seen_q <= '0;
            to_q       <= '0;
            mf_q       <= '0;
            rbd_q      <= '0;
            err_q      <= '0;
            resync_q   <= '0;
            sync_n_q   <= 1'b1;
            release_q  <= 1'b0;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lmfc_q     <= i_lmfc;
            k_cnt_q    <= k_cnt_d;
            cgs_ok_q   <= cgs_ok_d;
            ila_seen_q <= ila_seen_d;
            to_q       <= to_d;
            mf_q       <= mf_d;
            rbd_q      <= rbd_d;
            err_q      <= err_d;
            resync_q   <= resync_d;
            sync_n_q   <= sync_n_d;
            release_q  <= release_d;
            link_up_q  <= link_up_d;
        end
    end
endmodule

// File: tb/tb_jesd204b_rx_link_ctrl.sv
// tb_jesd204b_rx_link_ctrl: directed bring-up scenarios plus random traffic against a behavioural link model
module tb_jesd204b_rx_link_ctrl;
    localparam int K_CNT = 4, MF = 4, TO = 4, RBD = 3, THR = 4;
    localparam int S_IDLE = 0, S_WS = 1, S_CGS = 2, S_WI = 3, S_ILAS = 4, S_DATA = 5;

    logic       dclk, rst, i_enable, i_sysref_done, i_lmfc;
    logic [1:0] i_lane_k28_5, i_lane_ila_start, i_lane_err;
    logic       o_sync_n, o_release, o_link_up;
    logic [2:0] o_state;
    logic [7:0] o_resync_cnt;

    int n_chk = 0, n_fail = 0, ph = 0;
    int m_state, m_run[2], m_seen[2], m_lock, m_bnd, m_trel, m_errs, m_rsc, m_prev, m_cyc, m_edge;

    jesd204b_rx_link_ctrl #(.LANES(2), .CGS_K_CNT(K_CNT), .ILAS_MF(MF), .ILAS_TIMEOUT(TO),
                            .RBD(RBD), .ERR_THRESH(THR)) dut (
        .dclk(dclk), .rst(rst), .i_enable(i_enable), .i_sysref_done(i_sysref_done),
        .i_lmfc(i_lmfc), .i_lane_k28_5(i_lane_k28_5), .i_lane_ila_start(i_lane_ila_start),
        .i_lane_err(i_lane_err), .o_sync_n(o_sync_n), .o_release(o_release),
        .o_link_up(o_link_up), .o_state(o_state), .o_resync_cnt(o_resync_cnt));

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clear_aux();
        m_run = '{0, 0};
        m_seen = '{0, 0};
        m_lock = 0;
        m_bnd = 0;
        m_trel = -1;
        m_errs = 0;
    endtask

    // Link behaviour described in terms of K runs, boundaries seen and release time
    task automatic model_step();
        int nxt, errs;
        bit resync;
        m_cyc++;
        m_edge = i_lmfc && !m_prev;
        m_prev = i_lmfc;
        if (rst) begin
            m_state = S_IDLE; m_rsc = 0; m_prev = 0; clear_aux(); return;
        end
        if (!i_enable) begin
            m_state = S_IDLE; clear_aux(); return;
        end
        nxt = m_state;
        resync = 0;
        errs = i_lane_err[0] + i_lane_err[1];
        case (m_state)
            S_IDLE: nxt = S_WS;
            S_WS: if (i_sysref_done) nxt = S_CGS;
            S_CGS: begin
                for (int l = 0; l < 2; l++)
                    m_run[l] = (i_lane_k28_5[l] && !i_lane_err[l]) ? ((m_run[l] + 1 > K_CNT) ? K_CNT : m_run[l] + 1) : 0;
                if (m_run[0] >= K_CNT && m_run[1] >= K_CNT) m_lock = 1;
                if (m_lock && m_edge) nxt = S_WI;
            end
            S_WI: begin
                for (int l = 0; l < 2; l++) if (i_lane_ila_start[l]) m_seen[l] = 1;
                if (m_seen[0] && m_seen[1]) nxt = S_ILAS;
                else if (m_edge) begin
                    m_bnd++;
                    if (m_bnd == TO) resync = 1;
                end
            end
            S_ILAS: begin
                if (m_trel < 0 && m_edge) begin
                    m_bnd++;
                    if (m_bnd == MF) m_trel = m_cyc;
                end
                if (m_trel >= 0 && m_cyc == m_trel + RBD) nxt = S_DATA;
            end
            default: begin
                m_errs = (m_edge ? 0 : m_errs) + errs;
                if (m_errs > 255) m_errs = 255;
                if (m_errs >= THR) resync = 1;
            end
        endcase
        if (resync) begin
            nxt = S_CGS;
            if (m_rsc < 255) m_rsc++;
        end
        if (nxt != m_state) clear_aux();
        m_state = nxt;
    endtask

    task automatic step();
        @(posedge dclk);
        model_step();
        #1;
        check("state", int'(o_state), m_state);
        check("sync_n", int'(o_sync_n), (m_state != S_CGS) ? 1 : 0);
        check("release", int'(o_release), (m_state == S_DATA) ? 1 : 0);
        check("link_up", int'(o_link_up), (m_state == S_DATA) ? 1 : 0);
        check("resync_cnt", int'(o_resync_cnt), m_rsc);
        ph++;
        i_lmfc = (ph % 8) >= 4;
    endtask

    task automatic run_to(input int target, input int budget);
        for (int j = 0; j < budget && m_state != target; j++) begin
            rst = 0; i_enable = 1; i_lane_k28_5 = 2'b11; i_lane_err = 2'b00;
            i_sysref_done = (m_state == S_WS);
            i_lane_ila_start = (m_state == S_WI) ? 2'b11 : 2'b00;
            step();
        end
        i_sysref_done = 0; i_lane_ila_start = 2'b00;
        if (m_state != target) check("reach", int'(o_state), target);
    endtask

    task automatic to_edge();
        step();
        for (int j = 0; j < 16 && !m_edge; j++) step();
    endtask

    initial begin
        rst = 1; i_enable = 0; i_sysref_done = 0; i_lmfc = 0;
        i_lane_k28_5 = 0; i_lane_ila_start = 0; i_lane_err = 0;
        m_state = S_IDLE; m_rsc = 0; m_prev = 0; m_cyc = 0; m_edge = 0; clear_aux();
        repeat (3) step();
        check("rst_state", int'(o_state), S_IDLE);
        check("rst_sync_n", int'(o_sync_n), 1);
        check("rst_release", int'(o_release), 0);
        check("rst_link_up", int'(o_link_up), 0);
        check("rst_resync", int'(o_resync_cnt), 0);
        rst = 0; i_enable = 1; i_lane_k28_5 = 2'b11;
        repeat (4) step();
        i_sysref_done = 1; step(); i_sysref_done = 0;
        check("sync_fall", int'(o_sync_n), 0);
        run_to(S_WI, 100);
        run_to(S_DATA, 200);
        check("bringup_release", int'(o_release), 1);
        // broken K stream on lane 1
        i_enable = 0; step(); i_enable = 1;
        run_to(S_CGS, 20);
        for (int j = 0; j < 8; j++) begin
            i_lane_k28_5 = {(j != 3), 1'b1};
            step();
        end
        run_to(S_WI, 100);
        // only lane 0 starts ILAS
        i_lane_ila_start = 2'b01; step(); i_lane_ila_start = 2'b00; i_lane_k28_5 = 2'b00;
        repeat (40) step();
        check("ilas_to_state", int'(o_state), S_CGS);
        check("ilas_to_resync", int'(o_resync_cnt), 1);
        check("ilas_to_sync_n", int'(o_sync_n), 0);
        // errors in DATA
        run_to(S_DATA, 300);
        to_edge();
        i_lane_err = 2'b01; repeat (3) step(); i_lane_err = 2'b00;
        to_edge();
        check("err3_stay", int'(o_state), S_DATA);
        i_lane_err = 2'b11; repeat (2) step(); i_lane_err = 2'b00;
        check("err4_link_up", int'(o_link_up), 0);
        check("err4_sync_n", int'(o_sync_n), 0);
        check("err4_resync", int'(o_resync_cnt), 2);
        // disable mid-ILAS
        run_to(S_ILAS, 300);
        repeat (2) step();
        i_enable = 0; step();
        check("dis_state", int'(o_state), S_IDLE);
        check("dis_sync_n", int'(o_sync_n), 1);
        check("dis_resync", int'(o_resync_cnt), 2);
        // reset while in DATA
        run_to(S_DATA, 300);
        rst = 1; step(); rst = 0;
        check("rst_data_state", int'(o_state), S_IDLE);
        check("rst_data_release", int'(o_release), 0);
        check("rst_data_resync", int'(o_resync_cnt), 0);
        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 999) == 0);
            i_enable = ($urandom_range(0, 399) != 0);
            i_sysref_done = ($urandom_range(0, 9) == 0);
            for (int l = 0; l < 2; l++) begin
                i_lane_k28_5[l] = ($urandom_range(0, 15) != 0);
                i_lane_ila_start[l] = ($urandom_range(0, 3) == 0);
                i_lane_err[l] = ($urandom_range(0, 19) == 0);
            end
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
